fa_bist_checker: RTL and testbench



---
 rtl/fa_bist_checker_if.sv | 28 ++
 rtl/fa_bist_checker.sv | 218 +++++++++++++++++++++
 tb/tb_fa_bist_checker.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fa_bist_checker_if.sv
// Bundles the full-adder BIST control, stimulus and result signals.
// slave is the checker side, master the controller/adder side.
interface fa_bist_checker_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             a;
    logic             b;
    logic             c;
    logic             dut_sum;
    logic             dut_carry;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [2:0]       first_fail;
    logic             fail_seen;

    modport slave (
        input  start, dut_sum, dut_carry,
        output a, b, c, busy, done, pass, err_cnt, first_fail, fail_seen
    );

    modport master (
        output start, dut_sum, dut_carry,
        input  a, b, c, busy, done, pass, err_cnt, first_fail, fail_seen
    );
endinterface

// File: rtl/fa_bist_checker.sv
// Full-adder BIST engine: drives {a,b,c} sweeps and checks the delayed {carry,sum} response.
// Define FA_BIST_LFSR_EN to replace the 0..7 counter with an 8-bit LFSR pattern source.
module fa_bist_checker #(
    parameter int LATENCY    = 0,
    parameter int NUM_PASSES = 1,
    parameter int ERR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    fa_bist_checker_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

`ifdef FA_BIST_LFSR_EN
    localparam logic [7:0] IDX_LAST = 8'd254;
`else
    localparam logic [7:0] IDX_LAST = 8'd7;
`endif
    localparam logic [7:0]       PASS_LAST  = 8'(NUM_PASSES - 1);
    localparam logic [2:0]       DRAIN_LAST = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);
    localparam logic [ERR_W-1:0] ERR_MAX    = '1;

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_idx;
    logic [7:0]       r_pass_cnt;
    logic [2:0]       r_drain_cnt;
    logic [2:0]       r_abc;
    logic [ERR_W-1:0] r_err_cnt;
    logic [2:0]       r_first_fail;
    logic             r_fail_seen;

    logic             w_clear;
    logic             w_last_vec;
    logic             w_last;
    logic [2:0]       w_vec_next;
    logic [2:0]       w_vec_seed;

    logic             w_s0_valid;
    logic [2:0]       w_s0_vec;
    logic [1:0]       w_s0_exp;
    logic             w_cmp_valid;
    logic [2:0]       w_cmp_vec;
    logic [1:0]       w_cmp_exp;
    logic             w_mismatch;

`ifdef FA_BIST_LFSR_EN
    logic [7:0] r_lfsr;
    logic [7:0] w_lfsr_next;
    logic       w_lfsr_fb;

    // Taps 8,6,5,4: maximal length, so the sequence returns to the seed after 255 steps
    assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_lfsr_next = {r_lfsr[6:0], w_lfsr_fb};
    assign w_vec_next  = w_lfsr_next[2:0];
    assign w_vec_seed  = 3'b001;
`else
    assign w_vec_next  = r_abc + 3'd1;
    assign w_vec_seed  = 3'd0;
`endif

    assign w_last_vec = (r_idx == IDX_LAST);
    assign w_last     = w_last_vec && (r_pass_cnt == PASS_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_state_next = ST_RUN;
                    w_clear      = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = (LATENCY == 0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Stage 0 is the vector on the pins this cycle together with its golden response
    assign w_s0_valid = (r_state == ST_RUN);
    assign w_s0_vec   = r_abc;
    assign w_s0_exp   = {(r_abc[2] & r_abc[1]) | (r_abc[2] & r_abc[0]) | (r_abc[1] & r_abc[0]),
                         r_abc[2] ^ r_abc[1] ^ r_abc[0]};

    generate
        if (LATENCY == 0) begin : g_no_pipe
            assign w_cmp_valid = w_s0_valid;
            assign w_cmp_vec   = w_s0_vec;
            assign w_cmp_exp   = w_s0_exp;
        end else begin : g_pipe
            for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
                logic       r_valid;
                logic [2:0] r_vec;
                logic [1:0] r_exp;
                if (gi == 0) begin : g_head
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            r_valid <= 1'b0;
                            r_vec   <= 3'd0;
                            r_exp   <= 2'd0;
                        end else begin
                            r_valid <= w_s0_valid;
                            r_vec   <= w_s0_vec;
                            r_exp   <= w_s0_exp;
                        end
                    end
                end else begin : g_body
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            r_valid <= 1'b0;
                            r_vec   <= 3'd0;
                            r_exp   <= 2'd0;
                        end else begin
                            r_valid <= g_stage[gi-1].r_valid;
                            r_vec   <= g_stage[gi-1].r_vec;
                            r_exp   <= g_stage[gi-1].r_exp;
                        end
                    end
                end
            end
            assign w_cmp_valid = g_stage[LATENCY-1].r_valid;
            assign w_cmp_vec   = g_stage[LATENCY-1].r_vec;
            assign w_cmp_exp   = g_stage[LATENCY-1].r_exp;
        end
    endgenerate

    assign w_mismatch = w_cmp_valid && ({bus.dut_carry, bus.dut_sum} != w_cmp_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= 8'd0;
            r_pass_cnt   <= 8'd0;
            r_drain_cnt  <= 3'd0;
            r_abc        <= 3'd0;
            r_err_cnt    <= '0;
            r_first_fail <= 3'd0;
            r_fail_seen  <= 1'b0;
`ifdef FA_BIST_LFSR_EN
            r_lfsr       <= 8'h01;
`endif
        end else if (w_clear) begin
            r_idx        <= 8'd0;
            r_pass_cnt   <= 8'd0;
            r_drain_cnt  <= 3'd0;
            r_abc        <= w_vec_seed;
            r_err_cnt    <= '0;
            r_first_fail <= 3'd0;
            r_fail_seen  <= 1'b0;
`ifdef FA_BIST_LFSR_EN
            r_lfsr       <= 8'h01;
`endif
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_last) begin
                        r_abc       <= 3'd0;
                        r_drain_cnt <= 3'd0;
                    end else begin
                        r_abc <= w_vec_next;
`ifdef FA_BIST_LFSR_EN
                        r_lfsr <= w_lfsr_next;
`endif
                        if (w_last_vec) begin
                            r_idx      <= 8'd0;
                            r_pass_cnt <= r_pass_cnt + 8'd1;
                        end else begin
                            r_idx <= r_idx + 8'd1;
                        end
                    end
                end
                ST_DRAIN: r_drain_cnt <= r_drain_cnt + 3'd1;
                default: ;
            endcase
            if (w_mismatch) begin
                if (r_err_cnt != ERR_MAX) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                if (!r_fail_seen) begin
                    r_first_fail <= w_cmp_vec;
                    r_fail_seen  <= 1'b1;
                end
            end
        end
    end

    assign bus.a          = r_abc[2];
    assign bus.b          = r_abc[1];
    assign bus.c          = r_abc[0];
    assign bus.busy       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.pass       = (r_state == ST_DONE) && (r_err_cnt == '0);
    assign bus.err_cnt    = r_err_cnt;
    assign bus.first_fail = r_first_fail;
    assign bus.fail_seen  = r_fail_seen;
endmodule

// File: tb/tb_fa_bist_checker.sv
// Bench for fa_bist_checker: three checker configurations, each beside a behavioural
// adder with selectable faults; run results are scored against a queued expectation.
module tb_fa_bist_checker;
    typedef struct {
        int err;
        int ff;
        int seen;
        int pass;
        int cycles;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start_v;
    int         mode_v [3];
    int         n_tests = 0;
    int         n_fail  = 0;
    exp_t       sb_q [$];

    always #5 clk = ~clk;

    fa_bist_checker_if #(.ERR_W(8)) if0 ();
    fa_bist_checker_if #(.ERR_W(8)) if1 ();
    fa_bist_checker_if #(.ERR_W(8)) if2 ();

    fa_bist_checker #(.LATENCY(0), .NUM_PASSES(1),  .ERR_W(8)) u_l0   (.clk(clk), .rst(rst), .bus(if0));
    fa_bist_checker #(.LATENCY(2), .NUM_PASSES(1),  .ERR_W(8)) u_l2   (.clk(clk), .rst(rst), .bus(if1));
    fa_bist_checker #(.LATENCY(0), .NUM_PASSES(64), .ERR_W(8)) u_np64 (.clk(clk), .rst(rst), .bus(if2));

    logic [2:0] abc_w  [3];
    logic [7:0] err_w  [3];
    logic [2:0] ff_w   [3];
    logic [2:0] busy_w, done_w, pass_w, seen_w;

    assign abc_w  = '{{if0.a, if0.b, if0.c}, {if1.a, if1.b, if1.c}, {if2.a, if2.b, if2.c}};
    assign err_w  = '{if0.err_cnt, if1.err_cnt, if2.err_cnt};
    assign ff_w   = '{if0.first_fail, if1.first_fail, if2.first_fail};
    assign busy_w = {if2.busy, if1.busy, if0.busy};
    assign done_w = {if2.done, if1.done, if0.done};
    assign pass_w = {if2.pass, if1.pass, if0.pass};
    assign seen_w = {if2.fail_seen, if1.fail_seen, if0.fail_seen};
    assign if0.start = start_v[0];
    assign if1.start = start_v[1];
    assign if2.start = start_v[2];

    // {carry,sum} is simply the 2-bit arithmetic sum of the three inputs
    function automatic logic [1:0] fa_ref(input logic [2:0] v);
        return 2'(v[2] + v[1] + v[0]);
    endfunction

    // Modes: 0 good, 1 sum stuck-at-0, 2 carry inverted, 3 good behind two registers
    function automatic logic [1:0] fault_fn(input int mode, input logic [2:0] v);
        logic [1:0] g;
        g = fa_ref(v);
        case (mode)
            1:       return {g[1], 1'b0};
            2:       return {~g[1], g[0]};
            default: return g;
        endcase
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_fa
        logic [1:0] r_d1, r_d2;
        logic [1:0] w_resp;
        always_ff @(posedge clk) begin
            r_d1 <= fa_ref(abc_w[gi]);
            r_d2 <= r_d1;
        end
        always_comb begin
            w_resp = fault_fn(mode_v[gi], abc_w[gi]);
            if (mode_v[gi] == 3) begin
                w_resp = r_d2;
            end
        end
    end

    assign {if0.dut_carry, if0.dut_sum} = g_fa[0].w_resp;
    assign {if1.dut_carry, if1.dut_sum} = g_fa[1].w_resp;
    assign {if2.dut_carry, if2.dut_sum} = g_fa[2].w_resp;

    // Cycle-level reference: vector i is checked against the response seen lat cycles later
    function automatic exp_t model(input int mode, input int lat, input int np);
        exp_t e;
        int   dly, n, k;
        logic [2:0] v, rv;
        e   = '{err: 0, ff: 0, seen: 0, pass: 0, cycles: 0};
        dly = (mode == 3) ? 2 : 0;
        n   = 8 * np;
        for (int i = 0; i < n; i++) begin
            v  = 3'(i % 8);
            k  = i + lat - dly;
            rv = (k < 0 || k >= n) ? 3'd0 : 3'(k % 8);
            if (fault_fn((mode == 3) ? 0 : mode, rv) != fa_ref(v)) begin
                if (e.err < 255) e.err++;
                if (e.seen == 0) begin
                    e.ff   = int'(v);
                    e.seen = 1;
                end
            end
        end
        e.pass   = (e.err == 0) ? 1 : 0;
        e.cycles = n + lat;
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_test(input int u, input int mode, input int lat, input int np, input int repulse);
        exp_t e;
        int   cyc;
        int   budget;
        mode_v[u] = mode;
        @(negedge clk);
        start_v[u] = 1'b1;
        sb_q.push_back(model(mode, lat, np));
        @(negedge clk);
        start_v[u] = 1'b0;
        check_eq("clr_err",  32'(err_w[u]),  0);
        check_eq("clr_seen", 32'(seen_w[u]), 0);
        check_eq("clr_done", 32'(done_w[u]), 0);
        cyc    = 0;
        budget = 8 * np + lat + 16;
        while (busy_w[u] && cyc < budget) begin
            check_eq("vec", 32'(abc_w[u]), (cyc < 8 * np) ? 32'(cyc % 8) : 32'd0);
            start_v[u] = (repulse > 0 && cyc + 1 == repulse);
            cyc++;
            @(negedge clk);
        end
        start_v[u] = 1'b0;
        e = sb_q.pop_front();
        check_eq("busy_end",   32'(busy_w[u]), 0);
        check_eq("cycles",     cyc, e.cycles);
        check_eq("done",       32'(done_w[u]), 1);
        check_eq("pass",       32'(pass_w[u]), e.pass);
        check_eq("err_cnt",    32'(err_w[u]),  e.err);
        check_eq("fail_seen",  32'(seen_w[u]), e.seen);
        check_eq("first_fail", 32'(ff_w[u]),   e.ff);
        check_eq("abc_idle",   32'(abc_w[u]),  0);
        $display("[TB] run u=%0d mode=%0d lat=%0d np=%0d cycles=%0d err=%0d ff=%0d pass=%0d",
                 u, mode, lat, np, cyc, err_w[u], ff_w[u], pass_w[u]);
    endtask

    task automatic check_zero(input int u, input string tag);
        check_eq({tag, "_abc"},  32'(abc_w[u]),  0);
        check_eq({tag, "_busy"}, 32'(busy_w[u]), 0);
        check_eq({tag, "_done"}, 32'(done_w[u]), 0);
        check_eq({tag, "_pass"}, 32'(pass_w[u]), 0);
        check_eq({tag, "_err"},  32'(err_w[u]),  0);
        check_eq({tag, "_ff"},   32'(ff_w[u]),   0);
        check_eq({tag, "_seen"}, 32'(seen_w[u]), 0);
    endtask

    initial begin
        rst     = 1'b1;
        start_v = 3'b000;
        for (int i = 0; i < 3; i++) mode_v[i] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) check_zero(i, "reset");
        $display("[TB] reset state checked");

        run_test(0, 0, 0, 1, 0);
        run_test(0, 1, 0, 1, 0);
        run_test(0, 2, 0, 1, 0);
        run_test(2, 2, 0, 64, 0);
        run_test(1, 3, 2, 1, 0);
        run_test(0, 3, 0, 1, 0);
        run_test(0, 0, 0, 1, 4);

        mode_v[0] = 2;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("pre_rst_err", 32'(err_w[0] != 8'd0), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero(0, "midrst");
        $display("[TB] mid-run reset checked");
        run_test(0, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
